apb_requester: RTL and testbench

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester.sv | 121 ++++++++++++
 tb/tb_apb_requester.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_requester
//   Single-outstanding APB requester. Turns a valid/ready command into one
//   APB transfer (IDLE -> SETUP -> ACCESS) and returns a one-cycle response
//   pulse. If PREADY stays low for TIMEOUT consecutive ACCESS cycles, the
//   transfer is abandoned and an error response is returned.
//
// Ports
//   PCLK, PRESET         clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_write/addr/wdata command fields, captured on accept
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata/rsp_error  response payload, held until the next response
//   PSELx..PWDATA        APB requester outputs
//   PREADY, PRDATA       APB completer inputs
//
// Every output comes from a register or is decoded from the state register,
// so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module apb_requester #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 16   // legal range 2..255
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  PSELx,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t                r_state;
   logic [7:0]            r_wait;       // ACCESS cycles seen with PREADY low
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_error;
   logic                  w_last_wait;

   // True in the TIMEOUT-th consecutive ACCESS cycle; PREADY in that same
   // cycle still wins, so this only aborts when PREADY is low.
   assign w_last_wait = (r_wait == 8'(TIMEOUT - 1));

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= S_IDLE;
         r_wait      <= '0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_error <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_pwrite <= cmd_write;
                  r_paddr  <= cmd_addr;
                  r_pwdata <= cmd_wdata;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_wait  <= '0;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  r_state     <= S_IDLE;
                  r_pwrite    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_error <= 1'b0;
                  r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
               end else if (w_last_wait) begin
                  r_state     <= S_IDLE;
                  r_pwrite    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_error <= 1'b1;
                  r_rsp_rdata <= '0;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign PSELx     = (r_state != S_IDLE);
   assign PENABLE   = (r_state == S_ACCESS);
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_apb_requester.sv
// ---------------------------------------------------------------------------
// tb_apb_requester
//   Self-checking bench for apb_requester. A behavioural completer answers
//   APB transfers with a per-command number of wait states; a scoreboard
//   entry is pushed on every accepted command and popped on rsp_valid.
// ---------------------------------------------------------------------------
module tb_apb_requester;

   localparam int TMO = 16;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_error;
   logic       PSELx;
   logic       PENABLE;
   logic       PWRITE;
   logic [6:0] PADDR;
   logic [7:0] PWDATA;
   logic       PREADY;
   logic [7:0] PRDATA;

   apb_requester #(
      .ADDR_WIDTH (7),
      .DATA_WIDTH (8),
      .TIMEOUT    (TMO)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PRDATA    (PRDATA)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] rd;
      logic       err;
      int         cyc;
      int         acc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] cmem [128];   // completer storage
   logic [7:0] rmem [128];   // reference storage for expected read data
   int         cyc = 0;
   int         drv_dly = 0;  // wait states requested by the driver
   int         cur_dly = 0;  // wait states of the transfer in flight
   int         acc_k = 0;
   logic [6:0] cur_a = '0;
   logic       cur_w = 1'b0;
   logic [7:0] cur_d = '0;
   int         acc_seen = 0;
   int         setup_seen = 0;
   logic       prev_rv = 1'b0;
   logic [7:0] last_rd = '0;
   logic       last_err = 1'b0;

   initial begin
      for (int i = 0; i < 128; i++) begin
         cmem[i] = 8'(i) ^ 8'hA5;
         rmem[i] = 8'(i) ^ 8'hA5;
      end
   end

   always @(posedge PCLK) cyc <= cyc + 1;

   // Completer: PREADY rises after cur_dly low ACCESS cycles; outside ACCESS
   // PREADY/PRDATA carry noise that the requester must ignore.
   always @(negedge PCLK) begin
      if (PSELx && PENABLE) begin
         acc_k++;
         PREADY = (acc_k > cur_dly);
         PRDATA = cmem[PADDR];
      end else begin
         acc_k  = 0;
         PREADY = 1'($urandom_range(0, 1));
         PRDATA = 8'($urandom);
      end
   end

   always @(posedge PCLK) begin
      if (!PRESET && PSELx && PENABLE && PREADY && PWRITE)
         cmem[PADDR] <= PWDATA;
   end

   // Monitor / scoreboard
   always @(negedge PCLK) begin
      exp_t e;
      logic eerr;
      if (PRESET) begin
         sb.delete();
         last_rd  = '0;
         last_err = 1'b0;
         prev_rv  = 1'b0;
      end else begin
         if (PSELx) begin
            chk("paddr_stable", PADDR, cur_a);
            chk("pwrite_stable", PWRITE, cur_w);
            chk("pwdata_stable", PWDATA, cur_d);
            if (PENABLE) acc_seen++;
            else         setup_seen++;
         end else begin
            chk("idle_penable", PENABLE, 0);
            chk("idle_pwrite", PWRITE, 0);
         end
         if (rsp_valid) begin
            chk("rsp_single_pulse", prev_rv, 0);
            chk("rsp_cmd_ready", cmd_ready, 1);
            if (sb.size() == 0) begin
               chk("unexpected_rsp", rsp_valid, 0);
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rd);
               chk("rsp_error", rsp_error, e.err);
               chk("rsp_cycle", cyc, e.cyc);
               chk("access_cycles", acc_seen, e.acc);
               chk("setup_cycles", setup_seen, 1);
            end
            last_rd  = rsp_rdata;
            last_err = rsp_error;
         end else begin
            chk("rsp_rdata_hold", rsp_rdata, last_rd);
            chk("rsp_error_hold", rsp_error, last_err);
         end
         if (cmd_valid && cmd_ready) begin
            eerr    = (drv_dly >= TMO);
            e.err   = eerr;
            e.rd    = (eerr || cmd_write) ? 8'h00 : rmem[cmd_addr];
            e.cyc   = cyc + (eerr ? 2 + TMO : 3 + drv_dly);
            e.acc   = eerr ? TMO : drv_dly + 1;
            if (cmd_write && !eerr) rmem[cmd_addr] = cmd_wdata;
            sb.push_back(e);
            cur_a      = cmd_addr;
            cur_w      = cmd_write;
            cur_d      = cmd_wdata;
            cur_dly    = drv_dly;
            acc_seen   = 0;
            setup_seen = 0;
         end
         prev_rv = rsp_valid;
      end
   end

   // Caller must be just after a rising edge; returns just after the accept
   // edge with cmd_valid cleared so a following send keeps it high.
   task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, input int dly);
      int n;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      drv_dly   = dly;
      n = 0;
      @(negedge PCLK);
      while (!cmd_ready && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", cmd_ready, 1);
         cmd_valid = 1'b0;
      end else begin
         @(posedge PCLK);
         #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge PCLK);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      PRESET    = 1'b1;
      cmd_valid = 1'b1;   // reset must win over a pending command
      cmd_write = 1'b1;
      cmd_addr  = 7'h7F;
      cmd_wdata = 8'hFF;
      repeat (3) @(posedge PCLK);
      #1;
      PRESET    = 1'b0;
      cmd_valid = 1'b0;
      chk("reset_pselx", PSELx, 0);
      chk("reset_penable", PENABLE, 0);
      chk("reset_pwrite", PWRITE, 0);
      chk("reset_paddr", PADDR, 0);
      chk("reset_pwdata", PWDATA, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_error", rsp_error, 0);
      chk("reset_cmd_ready", cmd_ready, 1);
      @(posedge PCLK);
      #1;

      // Zero-wait write, then waited write and read of the same register
      send(1'b1, 7'h00, 8'h55, 0);
      drain();
      send(1'b1, 7'h04, 8'h55, 1);
      drain();
      send(1'b0, 7'h04, 8'h33, 2);
      drain();

      // PREADY never arrives: timeout
      send(1'b0, 7'h00, 8'h00, 255);
      drain();

      // Back-to-back writes then reads
      send(1'b1, 7'h10, 8'h01, 0);
      send(1'b1, 7'h11, 8'h02, 0);
      send(1'b1, 7'h12, 8'h03, 0);
      drain();
      send(1'b0, 7'h10, 8'h00, 0);
      send(1'b0, 7'h11, 8'h00, 0);
      send(1'b0, 7'h12, 8'h00, 0);
      drain();

      // Timeout boundary: ready on the last allowed cycle vs one cycle late
      send(1'b0, 7'h11, 8'h00, TMO - 1);
      drain();
      send(1'b0, 7'h11, 8'h00, TMO);
      drain();

      // Timed-out write must not land in the completer
      send(1'b1, 7'h20, 8'hAA, 255);
      drain();
      send(1'b0, 7'h20, 8'h00, 0);
      drain();

      // Mixed random traffic
      for (int i = 0; i < 10; i++) begin
         send(1'($urandom_range(0, 1)), 7'($urandom_range(8'h30, 8'h37)),
              8'($urandom), ($urandom_range(0, 3) == 0) ? 20 : int'($urandom_range(0, 4)));
      end
      drain();

      // Idle with noisy PREADY/PRDATA: bus must stay quiet
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         chk("idle_pselx", PSELx, 0);
      end
      @(posedge PCLK);
      #1;

      // Reset during ACCESS with PREADY high: silent abort
      send(1'b0, 7'h11, 8'h77, 0);
      @(posedge PCLK);
      #1;
      chk("pre_reset_in_access", PENABLE, 1);
      PRESET = 1'b1;
      @(posedge PCLK);
      #1;
      PRESET = 1'b0;
      chk("abort_pselx", PSELx, 0);
      chk("abort_penable", PENABLE, 0);
      chk("abort_paddr", PADDR, 0);
      chk("abort_pwdata", PWDATA, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_cmd_ready", cmd_ready, 1);
      @(negedge PCLK);
      chk("abort_no_rsp", rsp_valid, 0);
      @(posedge PCLK);
      #1;

      // Recovery after reset
      send(1'b0, 7'h12, 8'h00, 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
